// File: rtl/ber_rx.sv
// ber_rx: receive end of the PRBS9 + BPSK + RC link.
// Decimates the filter output at a selectable phase, slices each kept sample
// to a bit, self-synchronises a local PRBS9 reference (x^9 + x^5 + 1) and
// accumulates compared-bit and error counts for BER measurement.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   SYNC  | loading the reference with 9 received bits, no accumulation
//   CHECK | locked: compare against self-running reference, count errors
module ber_rx #(
    parameter int NB_DATA = 8,
    parameter int OS      = 4,
    parameter int NB_CNT  = 32,
    parameter int WIN     = 511,
    parameter int ERR_TH  = 64,
    localparam int PW     = $clog2(OS)
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic signed [NB_DATA-1:0] i_data,
    input  logic [PW-1:0]             i_phase,
    output logic                      o_bit,
    output logic                      o_bit_valid,
    output logic                      o_locked,
    output logic [NB_CNT-1:0]         o_bit_count,
    output logic [NB_CNT-1:0]         o_err_count,
    output logic                      o_ber_zero
);

    localparam int WW = $clog2(WIN + 1);
    localparam logic [WW-1:0] WIN_L    = WW'(WIN);
    localparam logic [WW-1:0] ERR_TH_L = WW'(ERR_TH);

    typedef enum logic {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ph_cnt;
    logic              strobe;
    logic              consume;
    logic [8:0]        r, r_nxt;
    logic [3:0]        sync_cnt, sync_nxt;
    logic [WW-1:0]     win_cnt, win_cnt_nxt;
    logic [WW-1:0]     win_err, win_err_nxt;
    logic [NB_CNT-1:0] bcnt_nxt, ecnt_nxt;
    logic              exp_bit;
    logic              err;

    assign strobe  = i_enable & (ph_cnt == i_phase);
    assign consume = o_bit_valid & i_enable;
    assign exp_bit = r[8] ^ r[4];
    assign err     = exp_bit ^ o_bit;

    // Phase counter and slicer: keep one sample per symbol, sign decides the bit.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            ph_cnt      <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
        end else begin
            if (i_enable)
                ph_cnt <= (ph_cnt == PW'(OS - 1)) ? '0 : ph_cnt + 1'b1;
            o_bit_valid <= strobe;
            if (strobe)
                o_bit <= ~i_data[NB_DATA-1];
        end
    end

    // Checker next state: sync loading, reference prediction, counting and
    // window-based loss-of-lock detection.
    always_comb begin
        state_nxt   = state;
        r_nxt       = r;
        sync_nxt    = sync_cnt;
        win_cnt_nxt = win_cnt;
        win_err_nxt = win_err;
        bcnt_nxt    = o_bit_count;
        ecnt_nxt    = o_err_count;
        if (consume) begin
            case (state)
                SYNC: begin
                    r_nxt = {r[7:0], o_bit};
                    if (sync_cnt == 4'd8) begin
                        sync_nxt = '0;
                        if (r_nxt != '0) begin
                            state_nxt   = CHECK;
                            win_cnt_nxt = '0;
                            win_err_nxt = '0;
                        end
                    end else begin
                        sync_nxt = sync_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    // Feeding back the prediction keeps one bad bit from
                    // corrupting the following predictions.
                    r_nxt = {r[7:0], exp_bit};
                    if (o_bit_count != '1)
                        bcnt_nxt = o_bit_count + 1'b1;
                    if (err && (o_err_count != '1))
                        ecnt_nxt = o_err_count + 1'b1;
                    win_cnt_nxt = win_cnt + 1'b1;
                    win_err_nxt = win_err + {{(WW-1){1'b0}}, err};
                    if (win_cnt_nxt == WIN_L) begin
                        if (win_err_nxt >= ERR_TH_L) begin
                            state_nxt = SYNC;
                            r_nxt     = '0;
                            sync_nxt  = '0;
                        end
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    // Checker registers.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= SYNC;
            r           <= '0;
            sync_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else begin
            state       <= state_nxt;
            r           <= r_nxt;
            sync_cnt    <= sync_nxt;
            win_cnt     <= win_cnt_nxt;
            win_err     <= win_err_nxt;
            o_bit_count <= bcnt_nxt;
            o_err_count <= ecnt_nxt;
        end
    end

    assign o_locked   = (state == CHECK);
    assign o_ber_zero = o_locked & (o_err_count == '0) & (o_bit_count != '0);

endmodule

// File: doc/ber_rx.md
Name: ber_rx

Overview:
- Receive end of the PRBS9+BPSK+RC link.
- Takes the RC filter output samples (OS samples per symbol), decimates them at a selectable sampling phase, and slices each kept sample to a bit.
- Self-synchronises a local PRBS9 reference to the received bits and accumulates bit and error counts for BER measurement.
- Drives the BER-is-zero indicator LED and the lock indicator.

Parameters:
- NB_DATA, 8, width of signed input sample (two's complement).
- OS, 4, oversampling factor (samples per symbol, ≥2).
- NB_CNT, 32, width of bit/error accumulators.
- WIN, 511, symbols per lock-monitor window.
- ERR_TH, 64, errors within one window that force resync.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  RX enable (i_sw[1]); when low all state holds.
- i_data  in  NB_DATA  signed filter output sample, one per clock while enabled.
- i_phase  in  clog2(OS)  sampling offset within symbol (i_sw[3:2]).
- o_bit  out  1  sliced bit.
- o_bit_valid  out  1  one-cycle strobe, o_bit new.
- o_locked  out  1  checker in CHECK state.
- o_bit_count  out  NB_CNT  bits compared since last reset.
- o_err_count  out  NB_CNT  errors counted since last reset.
- o_ber_zero  out  1  o_locked & (o_err_count==0) & (o_bit_count!=0).

Behaviour:
- Reset: the clock edge with i_reset=1 clears every register.
  - Phase counter = 0, o_bit = 0, o_bit_valid = 0, state = SYNC, sync count = 0.
  - Reference register r[8:0] = 0, window counter and window error counter = 0.
  - o_bit_count = 0, o_err_count = 0; hence o_locked = 0, o_ber_zero = 0.
  - Reset has priority over i_enable and takes effect mid-operation, discarding partial sync.
- Phase counter:
  - Increments modulo OS on each enabled clock; holds when i_enable = 0.
  - Strobe = i_enable & (count == i_phase).
  - An i_phase change takes effect on the next compare. One symbol may be skipped or duplicated; no special handling.
- Slicer:
  - On a strobe edge, o_bit <= ~i_data[NB_DATA-1] (≥0 → 1, <0 → 0; zero decides 1) and o_bit_valid <= 1.
  - Otherwise o_bit_valid <= 0 and o_bit holds.
  - Latency: sample at edge N → o_bit at edge N+1.
- Checker: consumes o_bit on edges where o_bit_valid = 1 and i_enable = 1. PRBS9 recurrence b[n] = b[n-9] ^ b[n-5] (x^9+x^5+1, same as the TX prbs9).
  - SYNC:
    - r <= {r[7:0], o_bit}; sync count++.
    - After the 9th bit: if r ≠ 0, go to CHECK and clear the window counters; else restart SYNC (sync count = 0).
    - No accumulation in SYNC.
  - CHECK:
    - exp = r[8] ^ r[4]; err = exp ^ o_bit.
    - r <= {r[7:0], exp}: feed back the expected bit, not the received bit, so there is no error propagation.
    - o_bit_count += 1, o_err_count += err; both saturate at all-ones.
    - Window: win_cnt++, win_err += err.
    - When win_cnt reaches WIN: if win_err ≥ ERR_TH, go to SYNC (r and sync count cleared); in either case win_cnt = win_err = 0.
    - Global counters are never cleared except by reset.
  - Simultaneous window-end and error: that symbol's err is included in win_err before the threshold test.
- Counter update latency: 2 clocks from the strobed sample.
- i_enable = 0: no strobes, no counter, state or register changes; o_bit_valid = 0 from the next edge.

Test Plan:
- Reset values: hold i_reset = 1 for 3 clocks with random i_data → all outputs 0, o_locked = 0, o_ber_zero = 0.
- Clean lock: TX prbs9 (seed 0x1AA) mapped to +64/−64, each symbol repeated 4×, i_phase = 0, enable → o_locked rises after the 9th o_bit_valid. After 1000 symbols, o_bit_count = 991, o_err_count = 0, o_ber_zero = 1.
- Phase select: same stream with i_phase = 3 and a 1-sample channel delay → still 0 errors. Decision of a zero sample = 1.
- Single error: after lock, invert one symbol's sign → o_err_count = 1, o_locked stays 1, o_ber_zero = 0, no further errors.
- Loss of lock: after lock, shift the stream by one symbol (drop 4 samples), WIN = 511, ERR_TH = 64 → about 50% errors. o_locked falls at the next window end, relocks 9 symbols later, and errors stop incrementing afterwards.
- All-zero / enable / reset: constant −64 input → never locks, counts stay 0. Deassert i_enable mid-CHECK for 20 clocks → counts frozen. Assert i_reset mid-CHECK → all counts 0, state SYNC next cycle.
